store_buffer: RTL and testbench
===============================

# store_buffer

Posted-write buffer between the MIPS core's data-store port (memwrite/dataadr/writedata) and the external data memory. Accepts CPU stores in a single cycle, queues them in a small FIFO, and drains them in order over a req/ack memory handshake. Stalls the core only when the queue is full. Detects loads that hit a pending store, and optionally forwards the data.

## Interface
- DEPTH, 4: number of entries; power of two, ≥2.
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low; clears all state.
- memwrite  input  1  CPU store request this cycle.
- dataadr  input  32  store byte address; bits [1:0] ignored.
- writedata  input  32  store data.
- byteen  input  4  store byte enables; bit i covers writedata[8i+7:8i].
- stall  output  1  store not accepted; combinational, equals memwrite & full.
- ld_valid  input  1  CPU load lookup this cycle.
- ld_adr  input  32  load byte address; bits [1:0] ignored.
- fwd_hit  output  1  load fully satisfied by a buffered store (combinational).
- fwd_data  output  32  forwarded word; valid when fwd_hit.
- ld_conflict  output  1  load overlaps a pending store that cannot be forwarded; core must stall the load.
- mem_req  output  1  head entry presented to memory.
- mem_adr  output  32  head word address; [1:0] = 0.
- mem_wdata  output  32  head data.
- mem_be  output  4  head byte enables.
- mem_ack  input  1  memory accepts the head entry at this edge.
- empty  output  1  no pending stores.
- count  output  $clog2(DEPTH)+1  occupancy.

## Operation
- Entry: {adr[31:2], data, be}. Stores with byteen==0 are accepted but not enqueued.
- Push: memwrite & !full enqueues at tail. When full, the store is refused (stall=1) even if mem_ack pops that cycle.
- Pop: mem_req & mem_ack at an edge retires head; mem_ack with mem_req=0 is ignored.
- Push and pop in the same cycle: count unchanged. Pointers wrap modulo DEPTH.
- Drain FSM: IDLE (empty, mem_req=0) -> BUSY on push. BUSY -> IDLE on pop when count==1 with no simultaneous push. Otherwise stays BUSY.
- mem_adr, mem_wdata and mem_be come from the head register. They are held stable while mem_req=1 and ack is absent.
- Load lookup on ld_valid compares word address against all valid entries. The youngest matching entry is used.
- No match: fwd_hit=0, ld_conflict=0.
- A store in the same cycle as a load to the same address is not visible to that lookup.

## Timing
- Reset values: mem_req=0, mem_adr=0, mem_wdata=0, mem_be=0, empty=1, count=0, fwd_hit=0, ld_conflict=0, FSM=IDLE.
- Reset mid-drain drops all entries and deasserts mem_req asynchronously. An outstanding ack is meaningless after reset.
- Store accepted at edge N appears on mem_* with mem_req=1 during cycle N+1 (1-cycle latency when empty).
- Back-to-back acks retire one entry per cycle. The next head is presented in the cycle after each ack.
- stall, fwd_hit, fwd_data and ld_conflict are combinational from current inputs and state. No registered delay.

## Configuration
- STORE_BUFFER_FWD_EN defined: on a youngest match with be==4'b1111, fwd_hit=1, fwd_data=entry data, and ld_conflict=0. On a youngest match with a partial be, ld_conflict=1 and fwd_hit=0.
- STORE_BUFFER_FWD_EN undefined: fwd_hit=0 and fwd_data=0 always. Any match sets ld_conflict=1.

## Structure
- Package store_buffer_pkg: entry typedef (adr[29:0], data[31:0], be[3:0]), FSM state enum {IDLE, BUSY}, and DEPTH default.
- One sub-module, sb_match: combinational youngest-match address compare across entries. Its outputs are hit, index and full-word flag.
- FIFO storage, pointers and the FSM live in store_buffer.

## Test plan
- Store 21 to 0x14 with byteen=F, mem_ack tied 1: mem_req=1 with mem_adr=0x14 and mem_wdata=21 the next cycle, then empty=1.
- mem_ack=0, 5 stores to 0x0/0x4/0x8/0xc/0x10: the first 4 are accepted, the 5th sees stall=1 and count=4. Raise ack: drain order is 0x0, 0x4, 0x8, 0xc, one per cycle.
- Full buffer with memwrite and mem_ack in the same cycle: store refused, count 4->3. Retried store accepted the next cycle.
- Store 0x550000ff then 0x1f to 0x18, load 0x18: with FWD_EN, fwd_hit=1 and fwd_data=0x1f. Without FWD_EN, ld_conflict=1.
- Store 0x0c with byteen=4'b0001 to 0xc, load 0xc: ld_conflict=1 and fwd_hit=0 in both builds.
- Assert reset low mid-drain with 3 entries: mem_req=0 immediately, count=0. The first store after reset appears alone on mem_*.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types for the posted-write store buffer: entry layout, drain FSM states, default depth.
package store_buffer_pkg;

  localparam int unsigned SB_DEPTH = 4;

  typedef struct packed {
    logic [29:0] adr;
    logic [31:0] data;
    logic [3:0]  be;
  } sb_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sb_state_e;

endpackage

// File: rtl/sb_match.sv
// Youngest-match word-address compare across the occupied entries of the store buffer.
module sb_match
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH
) (
  input  sb_entry_t [DEPTH-1:0]        entries_i,
  input  logic [$clog2(DEPTH)-1:0]     rd_ptr_i,
  input  logic [$clog2(DEPTH):0]       count_i,
  input  logic                         lookup_i,
  input  logic [29:0]                  adr_i,
  output logic                         hit_o,
  output logic [$clog2(DEPTH)-1:0]     index_o,
  output logic                         full_word_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit_o       = 1'b0;
    index_o     = '0;
    full_word_o = 1'b0;
    idx         = '0;
    if (lookup_i) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        idx = rd_ptr_i + PW'(k);
        if ((CW'(k) < count_i) && (entries_i[idx].adr == adr_i)) begin
          hit_o       = 1'b1;
          index_o     = idx;
          full_word_o = (entries_i[idx].be == 4'b1111);
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order FIFO drained over req/ack, with load-hit detection.
// Define STORE_BUFFER_FWD_EN to forward full-word hits to loads instead of flagging a conflict.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memwrite,
  input  logic [31:0]              dataadr,
  input  logic [31:0]              writedata,
  input  logic [3:0]               byteen,
  output logic                     stall,
  input  logic                     ld_valid,
  input  logic [31:0]              ld_adr,
  output logic                     fwd_hit,
  output logic [31:0]              fwd_data,
  output logic                     ld_conflict,
  output logic                     mem_req,
  output logic [31:0]              mem_adr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_be,
  input  logic                     mem_ack,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  sb_entry_t [DEPTH-1:0] mem_q;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  sb_state_e             state_q, state_d;

  logic      full, push, pop;
  sb_entry_t head;
  logic      m_hit, m_full;
  logic [PW-1:0] m_idx;

  assign full  = (count_q == CW'(DEPTH));
  // Zero-byte-enable stores are acknowledged to the core but never queued.
  assign push  = memwrite & ~full & (|byteen);
  assign pop   = mem_req & mem_ack;
  assign stall = memwrite & full;

  assign head      = mem_q[rd_ptr_q];
  assign mem_req   = (state_q == BUSY);
  assign mem_adr   = {head.adr, 2'b00};
  assign mem_wdata = head.data;
  assign mem_be    = head.be;
  assign empty     = (count_q == '0);
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (push) state_d = BUSY;
      BUSY:    if (pop && (count_q == CW'(1)) && !push) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
    end else begin
      if (push) mem_q[wr_ptr_q] <= '{adr: dataadr[31:2], data: writedata, be: byteen};
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  sb_match #(.DEPTH(DEPTH)) u_match (
    .entries_i   (mem_q),
    .rd_ptr_i    (rd_ptr_q),
    .count_i     (count_q),
    .lookup_i    (ld_valid),
    .adr_i       (ld_adr[31:2]),
    .hit_o       (m_hit),
    .index_o     (m_idx),
    .full_word_o (m_full)
  );

`ifdef STORE_BUFFER_FWD_EN
  logic unused_bits;
  assign unused_bits = ^{dataadr[1:0], ld_adr[1:0]};
  assign fwd_hit     = m_hit & m_full;
  assign fwd_data    = (m_hit & m_full) ? mem_q[m_idx].data : '0;
  assign ld_conflict = m_hit & ~m_full;
`else
  logic unused_bits;
  assign unused_bits = ^{dataadr[1:0], ld_adr[1:0], m_idx, m_full};
  assign fwd_hit     = 1'b0;
  assign fwd_data    = '0;
  assign ld_conflict = m_hit;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed table-driven bench for store_buffer plus hand-written reset-mid-drain sequence.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteen = '0;
  logic        stall;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_adr = '0;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        ld_conflict;
  logic        mem_req;
  logic [31:0] mem_adr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic        empty;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .byteen(byteen), .stall(stall), .ld_valid(ld_valid),
    .ld_adr(ld_adr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .ld_conflict(ld_conflict),
    .mem_req(mem_req), .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  // ld_kind: 0 = no match, 1 = youngest match is full-word (e_fd is its data), 2 = youngest match partial
  typedef struct {
    logic        mw;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        ack;
    logic        ldv;
    logic [31:0] lda;
    logic        e_stall;
    logic        e_req;
    logic [31:0] e_madr;
    logic [31:0] e_mwd;
    logic [3:0]  e_mbe;
    int          e_count;
    int          ld_kind;
    logic [31:0] e_fd;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic mw, logic [31:0] adr, logic [31:0] wd, logic [3:0] be,
                              logic ack, logic ldv, logic [31:0] lda,
                              logic e_stall, logic e_req, logic [31:0] e_madr,
                              logic [31:0] e_mwd, logic [3:0] e_mbe, int e_count,
                              int ld_kind, logic [31:0] e_fd);
    vec_t v;
    v.mw = mw; v.adr = adr; v.wd = wd; v.be = be; v.ack = ack; v.ldv = ldv; v.lda = lda;
    v.e_stall = e_stall; v.e_req = e_req; v.e_madr = e_madr; v.e_mwd = e_mwd;
    v.e_mbe = e_mbe; v.e_count = e_count; v.ld_kind = ld_kind; v.e_fd = e_fd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic mw, input logic [31:0] adr, input logic [31:0] wd,
                       input logic [3:0] be, input logic ack, input logic ldv, input logic [31:0] lda);
    memwrite = mw; dataadr = adr; writedata = wd; byteen = be;
    mem_ack = ack; ld_valid = ldv; ld_adr = lda;
  endtask

  initial begin
    logic        e_hit, e_conf;
    logic [31:0] e_fd;
    vec_t        v;

    // store 21 to 0x14 with ack tied high
    vq.push_back(mk(1, 32'h14, 32'd21, 4'hF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h14, 32'd21, 4'hF, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // fill with ack low, fifth store stalls, then in-order drain
    vq.push_back(mk(1, 32'h00, 32'h100, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 32'h04, 32'h104, 4'hF, 0, 0, 0, 0, 1, 32'h00, 32'h100, 4'hF, 1, 0, 0));
    vq.push_back(mk(1, 32'h08, 32'h108, 4'hF, 0, 0, 0, 0, 1, 32'h00, 32'h100, 4'hF, 2, 0, 0));
    vq.push_back(mk(1, 32'h0c, 32'h10c, 4'hF, 0, 0, 0, 0, 1, 32'h00, 32'h100, 4'hF, 3, 0, 0));
    vq.push_back(mk(1, 32'h10, 32'h110, 4'hF, 0, 0, 0, 1, 1, 32'h00, 32'h100, 4'hF, 4, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h00, 32'h100, 4'hF, 4, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h04, 32'h104, 4'hF, 3, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h08, 32'h108, 4'hF, 2, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h0c, 32'h10c, 4'hF, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // full buffer with store and ack in same cycle: refused, then retried
    vq.push_back(mk(1, 32'h20, 32'h220, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 32'h24, 32'h224, 4'hF, 0, 0, 0, 0, 1, 32'h20, 32'h220, 4'hF, 1, 0, 0));
    vq.push_back(mk(1, 32'h28, 32'h228, 4'hF, 0, 0, 0, 0, 1, 32'h20, 32'h220, 4'hF, 2, 0, 0));
    vq.push_back(mk(1, 32'h2c, 32'h22c, 4'hF, 0, 0, 0, 0, 1, 32'h20, 32'h220, 4'hF, 3, 0, 0));
    vq.push_back(mk(1, 32'h30, 32'h230, 4'hF, 1, 0, 0, 1, 1, 32'h20, 32'h220, 4'hF, 4, 0, 0));
    vq.push_back(mk(1, 32'h30, 32'h230, 4'hF, 0, 0, 0, 0, 1, 32'h24, 32'h224, 4'hF, 3, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h24, 32'h224, 4'hF, 4, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h28, 32'h228, 4'hF, 3, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h2c, 32'h22c, 4'hF, 2, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h30, 32'h230, 4'hF, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // load lookups: same-cycle invisibility, youngest match, miss, partial, be=0 ignored
    vq.push_back(mk(1, 32'h18, 32'h550000ff, 4'hF, 0, 1, 32'h18, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 32'h18, 32'h1f, 4'hF, 0, 1, 32'h18, 0, 1, 32'h18, 32'h550000ff, 4'hF, 1, 1, 32'h550000ff));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'h1b, 0, 1, 32'h18, 32'h550000ff, 4'hF, 2, 1, 32'h1f));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'h1c, 0, 1, 32'h18, 32'h550000ff, 4'hF, 2, 0, 0));
    vq.push_back(mk(1, 32'h0c, 32'h0c, 4'b0001, 0, 0, 0, 0, 1, 32'h18, 32'h550000ff, 4'hF, 2, 0, 0));
    vq.push_back(mk(1, 32'h40, 32'hdead, 4'b0000, 0, 1, 32'h0c, 0, 1, 32'h18, 32'h550000ff, 4'hF, 3, 2, 0));
    vq.push_back(mk(1, 32'h18, 32'hab, 4'b0011, 0, 1, 32'h40, 0, 1, 32'h18, 32'h550000ff, 4'hF, 3, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'h18, 0, 1, 32'h18, 32'h550000ff, 4'hF, 4, 2, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h18, 32'h550000ff, 4'hF, 4, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h18, 32'h1f, 4'hF, 3, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h0c, 32'h0c, 4'b0001, 2, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h18, 32'hab, 4'b0011, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // reset state
    #12;
    chk("reset mem_req", 32'(mem_req), 0);
    chk("reset mem_adr", mem_adr, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset mem_be", 32'(mem_be), 0);
    chk("reset empty", 32'(empty), 1);
    chk("reset count", 32'(count), 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      @(negedge clk);
      drive(v.mw, v.adr, v.wd, v.be, v.ack, v.ldv, v.lda);
      #1;
`ifdef STORE_BUFFER_FWD_EN
      e_hit  = (v.ld_kind == 1);
      e_fd   = (v.ld_kind == 1) ? v.e_fd : 32'h0;
      e_conf = (v.ld_kind == 2);
`else
      e_hit  = 1'b0;
      e_fd   = 32'h0;
      e_conf = (v.ld_kind != 0);
`endif
      chk($sformatf("v%0d stall", i), 32'(stall), 32'(v.e_stall));
      chk($sformatf("v%0d mem_req", i), 32'(mem_req), 32'(v.e_req));
      chk($sformatf("v%0d count", i), 32'(count), v.e_count);
      chk($sformatf("v%0d empty", i), 32'(empty), 32'(v.e_count == 0));
      chk($sformatf("v%0d fwd_hit", i), 32'(fwd_hit), 32'(e_hit));
      chk($sformatf("v%0d fwd_data", i), fwd_data, e_fd);
      chk($sformatf("v%0d ld_conflict", i), 32'(ld_conflict), 32'(e_conf));
      if (v.e_req) begin
        chk($sformatf("v%0d mem_adr", i), mem_adr, v.e_madr);
        chk($sformatf("v%0d mem_wdata", i), mem_wdata, v.e_mwd);
        chk($sformatf("v%0d mem_be", i), 32'(mem_be), 32'(v.e_mbe));
      end
    end

    // reset asserted mid-drain with three entries queued
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 32'h60 + 32'(4 * i), 32'h600 + 32'(i), 4'hF, 0, 0, 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("pre-reset mem_req", 32'(mem_req), 1);
    chk("pre-reset count", 32'(count), 3);
    chk("pre-reset mem_adr", mem_adr, 32'h60);
    #1 reset = 1'b0;
    #1;
    chk("async reset mem_req", 32'(mem_req), 0);
    chk("async reset count", 32'(count), 0);
    chk("async reset empty", 32'(empty), 1);
    chk("async reset mem_adr", mem_adr, 0);
    @(negedge clk);
    mem_ack = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    drive(1, 32'h70, 32'h77, 4'hF, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("post-reset mem_req", 32'(mem_req), 1);
    chk("post-reset mem_adr", mem_adr, 32'h70);
    chk("post-reset mem_wdata", mem_wdata, 32'h77);
    chk("post-reset count", 32'(count), 1);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("post-reset drained mem_req", 32'(mem_req), 0);
    chk("post-reset drained count", 32'(count), 0);
    chk("post-reset drained empty", 32'(empty), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
